// File: rtl/box_draw_datapath.sv
// Box sweep datapath/sequencer: draws a SIZE x SIZE box, paces with DELAY, erases and bounces.
// Optional feature macro: BOX_BOUNCE_Y_EN (vertical stepping with edge bounce).
module box_draw_datapath #(
  parameter int         SIZE   = 4,
  parameter int         X_MAX  = 160,
  parameter int         Y_MAX  = 120,
  parameter int         X_INIT = 0,
  parameter int         Y_INIT = 0,
  parameter int         DELAY  = 833333,
  parameter logic [2:0] COLOUR = 3'b111,
  parameter logic [2:0] BG     = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       draw_req,
  input  logic       erase_req,
  input  logic       step_en,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY - 1);
  localparam logic [7:0]    X_LIM  = 8'(X_MAX - SIZE);
  localparam logic [6:0]    Y_LIM  = 7'(Y_MAX - SIZE);
  localparam logic [6:0]    Y_FIX  = (Y_INIT > Y_MAX - SIZE) ? Y_LIM : 7'(Y_INIT);

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_WAIT, S_HOLD, S_ERASE, S_MOVE} state_t;

  // Returns {next_dir, next_pos}; at an edge the direction flips and the step goes the other way.
  function automatic logic [8:0] bounce_x(input logic [7:0] p, input logic up, input logic [7:0] lim);
    logic [8:0] r;
    if (lim == 8'd0)            r = {up, p};
    else if (up && p >= lim)    r = {1'b0, p - 8'd1};
    else if (!up && p == 8'd0)  r = {1'b1, 8'd1};
    else if (up)                r = {1'b1, p + 8'd1};
    else                        r = {1'b0, p - 8'd1};
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, row_q, row_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [7:0]      pos_x_q, pos_x_d;
  logic            dir_x_q, dir_x_d;
  logic            step_q, step_d;
  logic [6:0]      pos_y_d;
  logic            last_s;
  logic            plot_d, done_d;
  logic [7:0]      x_d, x_q;
  logic [6:0]      y_d, y_q;
  logic [2:0]      colour_d, colour_q;
  logic            plot_q, done_q;
`ifdef BOX_BOUNCE_Y_EN
  logic [6:0]      pos_y_q;
  logic            dir_y_q, dir_y_d;

  function automatic logic [7:0] bounce_y(input logic [6:0] p, input logic up, input logic [6:0] lim);
    logic [7:0] r;
    if (lim == 7'd0)            r = {up, p};
    else if (up && p >= lim)    r = {1'b0, p - 7'd1};
    else if (!up && p == 7'd0)  r = {1'b1, 7'd1};
    else if (up)                r = {1'b1, p + 7'd1};
    else                        r = {1'b0, p - 7'd1};
    return r;
  endfunction
`endif

  // Next-state, sweep counters, position stepping and next output values
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dly_d   = dly_q;
    pos_x_d = pos_x_q;
    dir_x_d = dir_x_q;
    step_d  = step_q;
`ifdef BOX_BOUNCE_Y_EN
    pos_y_d = pos_y_q;
    dir_y_d = dir_y_q;
`else
    pos_y_d = Y_FIX;
`endif
    last_s = (col_q == C_LAST) && (row_q == C_LAST);
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (erase_req) begin
          state_d = S_ERASE;
          step_d  = step_en;
          col_d   = '0;
          row_d   = '0;
        end else if (draw_req && state_q == S_IDLE) begin
          state_d = S_DRAW;
          col_d   = '0;
          row_d   = '0;
        end else if (!draw_req) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_DRAW, S_ERASE: begin
        if (state_q == S_DRAW && !draw_req) begin
          state_d = S_IDLE;
        end else if (last_s) begin
          state_d = (state_q == S_DRAW) ? S_WAIT : S_MOVE;
          dly_d   = '0;
        end else if (col_q == C_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!draw_req)            state_d = S_IDLE;
        else if (dly_q == D_LAST) state_d = S_HOLD;
        else                      dly_d   = dly_q + 1'b1;
      end
      S_MOVE: begin
        state_d = S_IDLE;
        if (step_q) begin
          {dir_x_d, pos_x_d} = bounce_x(pos_x_q, dir_x_q, X_LIM);
`ifdef BOX_BOUNCE_Y_EN
          {dir_y_d, pos_y_d} = bounce_y(pos_y_q, dir_y_q, Y_LIM);
`endif
        end else begin
          pos_x_d = pos_x_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    plot_d = (state_d == S_DRAW) || (state_d == S_ERASE);
    done_d = (state_d == S_HOLD);
    if (plot_d) begin
      x_d      = pos_x_d + 8'(col_d);
      y_d      = pos_y_d + 7'(row_d);
      colour_d = (state_d == S_DRAW) ? COLOUR : BG;
    end else begin
      x_d      = 8'd0;
      y_d      = 7'd0;
      colour_d = 3'd0;
    end
  end

  // State, counters, position and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      dly_q    <= '0;
      pos_x_q  <= 8'(X_INIT);
      dir_x_q  <= 1'b1;
      step_q   <= 1'b0;
`ifdef BOX_BOUNCE_Y_EN
      pos_y_q  <= Y_FIX;
      dir_y_q  <= 1'b1;
`endif
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dly_q    <= dly_d;
      pos_x_q  <= pos_x_d;
      dir_x_q  <= dir_x_d;
      step_q   <= step_d;
`ifdef BOX_BOUNCE_Y_EN
      pos_y_q  <= pos_y_d;
      dir_y_q  <= dir_y_d;
`endif
      plot_q   <= plot_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign done       = done_q;

endmodule

// File: tb/tb_box_draw_datapath.sv
// Self-checking bench for box_draw_datapath: directed scenarios plus randomized traffic against a
// transaction-level model (pixel index sweep, triangle-wave position from a step count).
module tb_box_draw_datapath;
  localparam int S  = 2;
  localparam int DL = 3;
  localparam int XM = 4;
  localparam int YM = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       draw_req = 1'b0;
  logic       erase_req = 1'b0;
  logic       step_en = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       done;

  box_draw_datapath #(
    .SIZE(S), .X_MAX(XM), .Y_MAX(YM), .X_INIT(0), .Y_INIT(0), .DELAY(DL),
    .COLOUR(3'b111), .BG(3'b000)
  ) dut (
    .clock(clock), .resetn(resetn), .draw_req(draw_req), .erase_req(erase_req),
    .step_en(step_en), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Position after n steps bouncing inside 0..lim is a triangle wave of period 2*lim.
  function automatic int tri_pos(input int n, input int lim);
    int p;
    if (lim == 0) return 0;
    p = n % (2 * lim);
    return (p <= lim) ? p : 2 * lim - p;
  endfunction

  // Model: 0 idle, 1 drawing, 2 pacing, 3 holding, 4 erasing, 5 moving
  int m_mode = 0, m_k = 0, m_w = 0, m_nx = 0, m_ny = 0;
  bit m_lat = 1'b0;

  always @(posedge clock) begin
    if (!resetn) begin
      m_mode <= 0; m_k <= 0; m_w <= 0; m_nx <= 0; m_ny <= 0; m_lat <= 1'b0;
    end else begin
      case (m_mode)
        0, 3: begin
          if (erase_req) begin
            m_mode <= 4; m_k <= 0; m_lat <= step_en;
          end else if (!draw_req) m_mode <= 0;
          else if (m_mode == 0) begin
            m_mode <= 1; m_k <= 0;
          end
        end
        1: begin
          if (!draw_req) m_mode <= 0;
          else if (m_k == S * S - 1) begin
            m_mode <= 2; m_w <= 0;
          end else m_k <= m_k + 1;
        end
        2: begin
          if (!draw_req) m_mode <= 0;
          else if (m_w + 1 == DL) m_mode <= 3;
          else m_w <= m_w + 1;
        end
        4: begin
          if (m_k == S * S - 1) m_mode <= 5;
          else m_k <= m_k + 1;
        end
        default: begin
          m_mode <= 0;
          if (m_lat) begin
            m_nx <= m_nx + 1;
            m_ny <= m_ny + 1;
          end
        end
      endcase
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clock) begin
    logic ep;
    int   ey;
    if (chk_en) begin
      ep = (m_mode == 1) || (m_mode == 4);
`ifdef BOX_BOUNCE_Y_EN
      ey = tri_pos(m_ny, YM - S);
`else
      ey = 0;
`endif
      check("plot", plot, ep);
      check("done", done, m_mode == 3);
      if (ep) begin
        check("x_out", x_out, tri_pos(m_nx, XM - S) + m_k % S);
        check("y_out", y_out, ey + m_k / S);
        check("colour", colour_out, (m_mode == 1) ? 7 : 0);
      end
    end
  end

  task automatic wait_draw();
    int n = 0;
    while (!(plot === 1'b1 && colour_out === 3'b111) && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("wait_draw_timeout", n < 64, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("wait_done_timeout", n < 64, 1);
  endtask

  task automatic pulse_erase();
    erase_req = 1'b1;
    step_en   = 1'b1;
    @(negedge clock);
    erase_req = 1'b0;
    step_en   = 1'b0;
  endtask

  int xs[4] = '{0, 1, 0, 1};
  int ys[4] = '{0, 0, 1, 1};
  int bx[4] = '{2, 1, 0, 1};
  int yb;
  logic dseen;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour_out, 0);
    chk_en = 1'b1;
    resetn = 1'b1;

    // Scenario 1: draw latency, pixel order, pacing, done
    draw_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      if (i <= 4) begin
        check("t1_plot", plot, 1);
        check("t1_x", x_out, xs[i-1]);
        check("t1_y", y_out, ys[i-1]);
        check("t1_colour", colour_out, 7);
      end else if (i <= 7) begin
        check("t1_wait_plot", plot, 0);
        check("t1_wait_done", done, 0);
      end else begin
        check("t1_done", done, 1);
      end
    end

    // Scenario 2: erase with step, redraw one pixel to the right
    pulse_erase();
    check("t2_erase_plot", plot, 1);
    check("t2_erase_colour", colour_out, 0);
    check("t2_erase_x", x_out, 0);
`ifdef BOX_BOUNCE_Y_EN
    yb = 1;
`else
    yb = 0;
`endif
    wait_draw();
    check("t2_x", x_out, 1);
    check("t6_y", y_out, yb);

    // Scenario 3: bounce sequence continues 2,1,0,1
    for (int i = 0; i < 4; i++) begin
      wait_done();
      pulse_erase();
      wait_draw();
      check("t3_x", x_out, bx[i]);
`ifdef BOX_BOUNCE_Y_EN
      check("t3_y", y_out, bx[i]);
`else
      check("t3_y", y_out, 0);
`endif
    end

    // Scenario 4: abort after second pixel
    wait_done();
    draw_req = 1'b0;
    repeat (2) @(negedge clock);
    draw_req = 1'b1;
    wait_draw();
    @(negedge clock);
    check("t4_second_pixel", plot, 1);
    draw_req = 1'b0;
    @(negedge clock);
    check("t4_abort_plot", plot, 0);
    dseen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      dseen = dseen | done;
    end
    check("t4_no_done", dseen, 0);

    // Scenario 5: reset during erase
    pulse_erase();
    @(negedge clock);
    check("t5_erasing", plot, 1);
    resetn = 1'b0;
    @(negedge clock);
    check("t5_plot", plot, 0);
    check("t5_done", done, 0);
    check("t5_x", x_out, 0);
    check("t5_colour", colour_out, 0);
    resetn   = 1'b1;
    draw_req = 1'b1;
    wait_draw();
    check("t5_pos_x", x_out, 0);
    check("t5_pos_y", y_out, 0);

    // Randomized traffic checked cycle by cycle against the model
    repeat (4000) begin
      @(negedge clock);
      draw_req  = ($urandom_range(0, 99) < 90);
      erase_req = ($urandom_range(0, 99) < 6);
      step_en   = $urandom_range(0, 1) == 1;
      resetn    = ($urandom_range(0, 999) >= 5);
    end
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
